// File: rtl/vga_pkg.sv
// vga_pkg: timing presets, sync polarity constants and a range-decode helper
package vga_pkg;
  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;
  function automatic logic in_rng(logic [31:0] x, logic [31:0] lo, logic [31:0] hi);
    return x >= lo && x < hi;
  endfunction
endpackage

// File: rtl/vga_addr_gen.sv
// vga_addr_gen: read strobe and framebuffer address sequencing with optional 2x replication
module vga_addr_gen #(
  parameter int SCALE  = 1,
  parameter int WIN_W  = 320,
  parameter int WIN_H  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              CLK25,
  input  logic              reset,
  input  logic              rd_win,
  input  logic              line_end,
  input  logic              frame_end,
  output logic              rd_en,
  output logic [ADDR_W-1:0] pixel_address
);
  localparam logic [ADDR_W-1:0] A_MAX = ADDR_W'(WIN_W * WIN_H - 1);
  logic [ADDR_W-1:0] addr, row_base;
  logic hphase, lphase, strobe;
  // at 2x only every other read-window cycle fetches, so a line still carries WIN_W strobes
  assign strobe = rd_win && (SCALE == 1 || !hphase);
  // addr is the next fetch; the first line of a pair rewinds to row_base, the second advances it
  always_ff @(posedge CLK25 or posedge reset)
    if (reset) begin
      rd_en <= 1'b0;
      pixel_address <= '0;
      addr <= '0;
      row_base <= '0;
      hphase <= 1'b0;
      lphase <= 1'b0;
    end else begin
      rd_en <= strobe;
      if (strobe) pixel_address <= addr;
      hphase <= rd_win ? !hphase : 1'b0;
      if (frame_end) begin
        addr <= '0;
        row_base <= '0;
        lphase <= 1'b0;
      end else if (line_end && SCALE == 2) begin
        lphase <= !lphase;
        if (!lphase) addr <= row_base;
        else row_base <= addr;
      end else if (strobe && addr != A_MAX) addr <= addr + ADDR_W'(1);
    end
endmodule

// File: rtl/vga_window_ctrl.sv
// vga_window_ctrl: VGA timing with windowed fetch; VGA_UNDERFLOW_CHK_EN adds a FIFO underflow monitor
module vga_window_ctrl
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = VGA640_H_ACTIVE,
  parameter int   H_FP     = VGA640_H_FP,
  parameter int   H_SYNC   = VGA640_H_SYNC,
  parameter int   H_BP     = VGA640_H_BP,
  parameter int   V_ACTIVE = VGA640_V_ACTIVE,
  parameter int   V_FP     = VGA640_V_FP,
  parameter int   V_SYNC   = VGA640_V_SYNC,
  parameter int   V_BP     = VGA640_V_BP,
  parameter logic HS_POL   = SYNC_ACTIVE_LOW,
  parameter logic VS_POL   = SYNC_ACTIVE_LOW,
  parameter int   WIN_X    = 160,
  parameter int   WIN_Y    = 120,
  parameter int   WIN_W    = 320,
  parameter int   WIN_H    = 240,
  parameter int   SCALE    = 1,
  parameter int   PREFETCH = 8,
  parameter int   ADDR_W   = 17
) (
  input  logic              CLK25,
  input  logic              reset,
  output logic              Hsync,
  output logic              Vsync,
  output logic              Nblank,
  output logic              Nsync,
  output logic              clkout,
  output logic              activeArea,
  output logic              rd_en,
  output logic [ADDR_W-1:0] pixel_address,
`ifdef VGA_UNDERFLOW_CHK_EN
  input  logic              fifo_empty,
  output logic              underflow,
  output logic [7:0]        underflow_cnt,
  output logic              frame_start
`else
  output logic              frame_start
`endif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  if (PREFETCH > WIN_X || WIN_X + WIN_W * SCALE > H_ACTIVE || WIN_Y + WIN_H * SCALE > V_ACTIVE ||
      (SCALE != 1 && SCALE != 2) || WIN_W * WIN_H > 2 ** ADDR_W) begin : g_cfg_err
    $error("vga_window_ctrl: window does not fit the panel or address space");
  end
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [31:0] hc, vc;
  logic h_last, v_last, win_v, hs_d, vs_d, nb_d, act_d, fs_d, rd_win, line_end, frame_end;
  assign hc = 32'(hcnt);
  assign vc = 32'(vcnt);
  assign Nsync = 1'b1;
  assign clkout = CLK25;
  // combinational decode of the current counter pair
  always_comb begin
    h_last = hc == H_TOTAL - 1;
    v_last = vc == V_TOTAL - 1;
    win_v = in_rng(vc, WIN_Y, WIN_Y + WIN_H * SCALE);
    hs_d = in_rng(hc, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC);
    vs_d = in_rng(vc, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC);
    nb_d = in_rng(hc, 0, H_ACTIVE) && in_rng(vc, 0, V_ACTIVE);
    act_d = in_rng(hc, WIN_X, WIN_X + WIN_W * SCALE) && win_v;
    rd_win = in_rng(hc, WIN_X - PREFETCH, WIN_X + WIN_W * SCALE - PREFETCH) && win_v;
    fs_d = hc == 0 && vc == 0;
    line_end = h_last && win_v;
    frame_end = h_last && v_last;
  end
  // pixel and line counters; the line counter steps when the pixel counter wraps
  always_ff @(posedge CLK25 or posedge reset)
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      hcnt <= h_last ? '0 : hcnt + HW'(1);
      if (h_last) vcnt <= v_last ? '0 : vcnt + VW'(1);
    end
  // decoded outputs, one cycle behind the counters
  always_ff @(posedge CLK25 or posedge reset)
    if (reset) begin
      Hsync <= ~HS_POL;
      Vsync <= ~VS_POL;
      Nblank <= 1'b0;
      activeArea <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      Hsync <= hs_d ? HS_POL : ~HS_POL;
      Vsync <= vs_d ? VS_POL : ~VS_POL;
      Nblank <= nb_d;
      activeArea <= act_d;
      frame_start <= fs_d;
    end
  vga_addr_gen #(.SCALE(SCALE), .WIN_W(WIN_W), .WIN_H(WIN_H), .ADDR_W(ADDR_W)) u_addr (
    .CLK25(CLK25),
    .reset(reset),
    .rd_win(rd_win),
    .line_end(line_end),
    .frame_end(frame_end),
    .rd_en(rd_en),
    .pixel_address(pixel_address)
  );
`ifdef VGA_UNDERFLOW_CHK_EN
  // sticky underflow flag and saturating count of strobes issued against an empty FIFO
  always_ff @(posedge CLK25 or posedge reset)
    if (reset) begin
      underflow <= 1'b0;
      underflow_cnt <= '0;
    end else if (rd_en && fifo_empty) begin
      underflow <= 1'b1;
      if (underflow_cnt != 8'hff) underflow_cnt <= underflow_cnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_vga_window_ctrl.sv
// tb_vga_window_ctrl: scoreboard bench on a reduced 60x32 raster, 2x window (u2) and 1x active-high-sync window (u1)
module tb_vga_window_ctrl;
  typedef struct {int cyc; int addr;} exp_t;
  logic CLK25 = 1'b0, reset = 1'b1, fe2 = 1'b0;
  logic hs2, vs2, nb2, ns2, co2, act2, rd2, fs2;
  logic hs1, vs1, nb1, ns1, co1, act1, rd1, fs1;
  logic [5:0] addr2;
  logic [4:0] addr1;
  logic uf2, uf1;
  logic [7:0] ufc2, ufc1;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int idx, h, v;
  logic hs_on, vs_on, nb_on;
  exp_t q2[$], q1[$], e;

  always #5 CLK25 = ~CLK25;

  vga_window_ctrl #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(10), .V_ACTIVE(24), .V_FP(2), .V_SYNC(3), .V_BP(3),
    .WIN_X(12), .WIN_Y(6), .WIN_W(8), .WIN_H(5), .SCALE(2), .PREFETCH(4), .ADDR_W(6)
  ) u2 (
    .CLK25(CLK25), .reset(reset), .Hsync(hs2), .Vsync(vs2), .Nblank(nb2), .Nsync(ns2), .clkout(co2),
    .activeArea(act2), .rd_en(rd2), .pixel_address(addr2),
`ifdef VGA_UNDERFLOW_CHK_EN
    .fifo_empty(fe2), .underflow(uf2), .underflow_cnt(ufc2),
`endif
    .frame_start(fs2)
  );

  vga_window_ctrl #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(10), .V_ACTIVE(24), .V_FP(2), .V_SYNC(3), .V_BP(3),
    .HS_POL(1'b1), .VS_POL(1'b1),
    .WIN_X(12), .WIN_Y(6), .WIN_W(8), .WIN_H(3), .SCALE(1), .PREFETCH(2), .ADDR_W(5)
  ) u1 (
    .CLK25(CLK25), .reset(reset), .Hsync(hs1), .Vsync(vs1), .Nblank(nb1), .Nsync(ns1), .clkout(co1),
    .activeArea(act1), .rd_en(rd1), .pixel_address(addr1),
`ifdef VGA_UNDERFLOW_CHK_EN
    .fifo_empty(1'b0), .underflow(uf1), .underflow_cnt(ufc1),
`endif
    .frame_start(fs1)
  );

`ifndef VGA_UNDERFLOW_CHK_EN
  assign uf2 = 1'b0;
  assign uf1 = 1'b0;
  assign ufc2 = 8'd0;
  assign ufc1 = 8'd0;
`endif

  // cycles since reset release; outputs sampled at negedge of cycle k reflect decode index k-1
  always @(posedge CLK25 or posedge reset) cyc <= reset ? 0 : cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < 20000 && cyc < n; i++) @(negedge CLK25);
    n_chk++;
    if (cyc != n) begin
      n_fail++;
      $display("FAIL wait_cyc: got %0d, expected %0d", cyc, n);
    end
  endtask

  // hand-derived fetch schedule for one frame starting at cycle base
  task automatic push_frame(input int base);
    for (int vv = 6; vv < 16; vv++)
      for (int i = 0; i < 8; i++) q2.push_back('{base + vv * 60 + 8 + 2 * i + 1, ((vv - 6) / 2) * 8 + i});
    for (int vv = 6; vv < 9; vv++)
      for (int i = 0; i < 8; i++) q1.push_back('{base + vv * 60 + 10 + i + 1, (vv - 6) * 8 + i});
  endtask

  task automatic chk_reset_vals();
    chk("u2 rd_en rst", rd2, 0);
    chk("u2 addr rst", addr2, 0);
    chk("u2 activeArea rst", act2, 0);
    chk("u2 Nblank rst", nb2, 0);
    chk("u2 frame_start rst", fs2, 0);
    chk("u2 Hsync rst", hs2, 1);
    chk("u2 Vsync rst", vs2, 1);
    chk("u1 rd_en rst", rd1, 0);
    chk("u1 addr rst", addr1, 0);
    chk("u1 Hsync rst", hs1, 0);
    chk("u1 Vsync rst", vs1, 0);
    chk("u2 Nsync", ns2, 1);
    chk("u2 underflow rst", uf2, 0);
    chk("u2 underflow_cnt rst", ufc2, 0);
  endtask

  // monitor: per-cycle timing checks and scoreboard pops on each strobe
  always @(negedge CLK25) begin
    if (!reset && cyc > 0) begin
      idx = cyc - 1;
      h = idx % 60;
      v = (idx / 60) % 32;
      hs_on = h >= 44 && h < 50;
      vs_on = v >= 26 && v < 29;
      nb_on = h < 40 && v < 24;
      chk("u2 Hsync", hs2, !hs_on);
      chk("u2 Vsync", vs2, !vs_on);
      chk("u1 Hsync", hs1, hs_on);
      chk("u1 Vsync", vs1, vs_on);
      chk("u2 Nblank", nb2, nb_on);
      chk("u1 Nblank", nb1, nb_on);
      chk("u2 activeArea", act2, h >= 12 && h < 28 && v >= 6 && v < 16);
      chk("u1 activeArea", act1, h >= 12 && h < 20 && v >= 6 && v < 9);
      chk("u2 frame_start", fs2, h == 0 && v == 0);
      chk("u1 frame_start", fs1, h == 0 && v == 0);
      chk("u2 clkout", co2, CLK25);
      while (q2.size() > 0 && q2[0].cyc < cyc) begin
        n_chk++; n_fail++;
        $display("FAIL u2 missed strobe: expected at cyc %0d addr %0d", q2[0].cyc, q2[0].addr);
        void'(q2.pop_front());
      end
      if (rd2) begin
        if (q2.size() == 0 || q2[0].cyc != cyc) begin
          n_chk++; n_fail++;
          $display("FAIL u2 unexpected strobe at cyc %0d addr %0d", cyc, addr2);
        end else begin
          e = q2.pop_front();
          chk("u2 addr", addr2, e.addr);
        end
      end
      while (q1.size() > 0 && q1[0].cyc < cyc) begin
        n_chk++; n_fail++;
        $display("FAIL u1 missed strobe: expected at cyc %0d addr %0d", q1[0].cyc, q1[0].addr);
        void'(q1.pop_front());
      end
      if (rd1) begin
        if (q1.size() == 0 || q1[0].cyc != cyc) begin
          n_chk++; n_fail++;
          $display("FAIL u1 unexpected strobe at cyc %0d addr %0d", cyc, addr1);
        end else begin
          e = q1.pop_front();
          chk("u1 addr", addr1, e.addr);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge CLK25);
    chk_reset_vals();
    push_frame(0);
    push_frame(1920);
    push_frame(3840);
    reset = 1'b0;
`ifdef VGA_UNDERFLOW_CHK_EN
    wait_cyc(369);
    chk("u2 underflow before", uf2, 0);
    fe2 = 1'b1;
    wait_cyc(374);
    fe2 = 1'b0;
    chk("u2 underflow set", uf2, 1);
    chk("u2 underflow_cnt", ufc2, 3);
    wait_cyc(3839);
    chk("u2 underflow held", uf2, 1);
    chk("u2 underflow_cnt held", ufc2, 3);
    chk("u1 underflow", uf1, 0);
`endif
    wait_cyc(4461);
    chk("u2 rd_en before reset", rd2, 1);
    chk("u2 activeArea before reset", act2, 1);
    #2 reset = 1'b1;
    #1 chk_reset_vals();
    chk("u1 activeArea rst", act1, 0);
    q2.delete();
    q1.delete();
    repeat (2) @(negedge CLK25);
    push_frame(0);
    reset = 1'b0;
    wait_cyc(1930);
    chk("u2 queue drained", q2.size(), 0);
    chk("u1 queue drained", q1.size(), 0);
    chk("u2 underflow after reset", uf2, 0);
    chk("u1 underflow_cnt", ufc1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
